// File: rtl/ssd_scan_controller.sv
// ssd_scan_controller
//   Time-multiplexed seven-segment display driver. Scans NUM_DIGITS
//   common-anode digits, one slot of SCAN_DIV clocks per digit, with the
//   first BLANK_CYCLES of every slot held dark to suppress ghosting.
//   New display data is captured into a staging buffer on `load` and copied
//   into the active buffer only at a frame boundary, so a frame never mixes
//   old and new contents.
//
// Optional feature macro: SSD_BRIGHTNESS_EN
//   Adds the `brightness` port and a 3-bit PWM gate on the lit anode.
//   Without it, there is no PWM logic and lit digits are on for the whole
//   unblanked part of their slot.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   load         strobe; captures digits_in / digit_en_in / dp_in into staging
//   digits_in    hex nibble per digit, digit i = [4i+3:4i] (digit 0 rightmost)
//   digit_en_in  per-digit enable (0 = dark, slot still consumed)
//   dp_in        per-digit decimal point (1 = lit)
//   brightness   (SSD_BRIGHTNESS_EN only) 0 = 1/8 duty, 7 = full
//   busy         staged data waiting for the next frame boundary
//   anode        active-low digit selects
//   ssdOut       active-low segments {g,f,e,d,c,b,a}
//   dp           active-low decimal point
//   frame_tick   1-cycle pulse in the first cycle of each frame
//
// Handshake: `load` has no ready. Any cycle with load=1 is accepted and
// overwrites staging (last write wins); `busy` reports that staging holds
// data not yet shown and drops in the cycle after the transfer.
module ssd_scan_controller #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 200
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   digit_en_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
`ifdef SSD_BRIGHTNESS_EN
    input  logic [2:0]              brightness,
`endif
    output logic                    busy,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              ssdOut,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK     = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           pcnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] stg_digits, act_digits;
    logic [NUM_DIGITS-1:0]   stg_en, act_en;
    logic [NUM_DIGITS-1:0]   stg_dp, act_dp;

    logic                    frame_end;
    logic                    gate;
    logic                    lit;
    logic [3:0]              cur_nib;
    logic [NUM_DIGITS-1:0]   sel;

`ifdef SSD_BRIGHTNESS_EN
    logic [2:0] pwm;
    logic [2:0] bright_act;
    assign gate = (pwm <= bright_act);
`else
    assign gate = 1'b1;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Last cycle of the last digit slot; everything frame-related keys off this.
    assign frame_end = (pcnt == PCNT_LAST) && (idx == IDX_LAST);

    always_comb begin
        sel      = '0;
        sel[idx] = 1'b1;
        cur_nib  = act_digits[{idx, 2'b00} +: 4];
        lit      = (pcnt >= BLANK) && act_en[idx] && gate;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt       <= '0;
            idx        <= '0;
            stg_digits <= '0;
            stg_en     <= '0;
            stg_dp     <= '0;
            act_digits <= '0;
            act_en     <= '0;
            act_dp     <= '0;
            busy       <= 1'b0;
            anode      <= '1;
            ssdOut     <= 7'h7F;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
`ifdef SSD_BRIGHTNESS_EN
            pwm        <= '0;
            bright_act <= 3'd7;
`endif
        end else begin
            if (pcnt == PCNT_LAST) begin
                pcnt <= '0;
                idx  <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                pcnt <= pcnt + PW'(1);
            end

            frame_tick <= frame_end;

            // Transfer reads the pre-edge staging contents, so a load landing
            // in the boundary cycle stays staged and re-asserts busy below.
            if (frame_end && busy) begin
                act_digits <= stg_digits;
                act_en     <= stg_en;
                act_dp     <= stg_dp;
                busy       <= 1'b0;
            end
            if (load) begin
                stg_digits <= digits_in;
                stg_en     <= digit_en_in;
                stg_dp     <= dp_in;
                busy       <= 1'b1;
            end

            // Only the current slot's anode can be low, so at most one digit is driven.
            anode  <= lit ? ~sel : '1;
            ssdOut <= lit ? seg7(cur_nib) : 7'h7F;
            dp     <= lit ? ~act_dp[idx] : 1'b1;

`ifdef SSD_BRIGHTNESS_EN
            pwm <= pwm + 3'd1;
            if (frame_end) begin
                bright_act <= brightness;
            end
`endif
        end
    end

endmodule
